// File: rtl/prom_loader_pkg.sv
// Shared types and constants for the PROM loader: FSM state encoding and the frame sync byte.
package prom_loader_pkg;

    typedef enum logic [2:0] {
        HUNT,
        LEN,
        LO,
        HI,
        WRITE,
        CHK,
        DONE,
        ERROR
    } state_e;

    localparam logic [7:0] SYNC_BYTE = 8'hA5;

    // True while a frame is being received or written.
    function automatic logic is_loading(input state_e s);
        return (s == LEN) || (s == LO) || (s == HI) || (s == WRITE) || (s == CHK);
    endfunction

endpackage

// File: rtl/byte_timer.sv
// Inter-byte idle timer: reloads on every accepted byte and counts down while running.
// expired_o flags the idle clock that uses up the last allowed tick.
module byte_timer #(
    parameter int TIMEOUT_TICKS = 625
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clear_i,
    input  logic run_i,
    output logic expired_o
);

    localparam int CW = $clog2(TIMEOUT_TICKS + 1);
    localparam logic [CW-1:0] LOAD = CW'(TIMEOUT_TICKS);

    logic [CW-1:0] count_q, count_d;

    assign expired_o = run_i && !clear_i && (count_q <= CW'(1));

    always_comb begin
        count_d = count_q;
        if (clear_i || expired_o) begin
            count_d = LOAD;
        end else if (run_i) begin
            count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= LOAD;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/prom_loader.sv
// Fills the instruction PROM from a framed UART byte stream and owns the CPU reset.
// Define PROM_LOADER_CHECKSUM_EN to require and verify the trailing CHK byte.
module prom_loader
    import prom_loader_pkg::*;
#(
    parameter int ROM_WORDS     = 16,
    parameter int TIMEOUT_TICKS = 625
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic [7:0]                   rx_data_i,
    input  logic                         rx_ready_i,
    output logic                         rx_ack_o,
    output logic                         prom_we_o,
    output logic [$clog2(ROM_WORDS)-1:0] prom_addr_o,
    output logic [15:0]                  prom_data_o,
    output logic                         cpu_reset_o,
    output logic                         load_busy_o,
    output logic                         load_done_o,
    output logic                         load_error_o
);

    localparam int AW = $clog2(ROM_WORDS);
    localparam logic [8:0] MAX_LEN = 9'(ROM_WORDS);

    state_e        state_q, state_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [7:0]    cnt_q, cnt_d;
    logic [7:0]    lo_q, lo_d;
    logic [15:0]   data_q, data_d;
    logic          we_q, we_d;
    logic          ack_q, ack_d;
    logic          cpu_reset_q, cpu_reset_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          error_q, error_d;

    logic byte_acc;
    logic is_sync;
    logic timer_run;
    logic timer_expired;

    assign byte_acc  = rx_ready_i && ack_q;
    assign is_sync   = (rx_data_i == SYNC_BYTE);
    assign timer_run = (state_q == LEN) || (state_q == LO) || (state_q == HI) || (state_q == CHK);

    byte_timer #(
        .TIMEOUT_TICKS(TIMEOUT_TICKS)
    ) u_byte_timer (
        .clk      (clk),
        .reset_n  (reset_n),
        .clear_i  (byte_acc),
        .run_i    (timer_run),
        .expired_o(timer_expired)
    );

`ifdef PROM_LOADER_CHECKSUM_EN
    logic [7:0] sum_q, sum_d;
    logic [7:0] sum_next;

    assign sum_next = sum_q + rx_data_i;
`endif

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        cnt_d   = cnt_q;
        lo_d    = lo_q;
        data_d  = data_q;
`ifdef PROM_LOADER_CHECKSUM_EN
        sum_d   = sum_q;
`endif
        case (state_q)
            HUNT, DONE, ERROR: begin
                if (byte_acc && is_sync) begin
                    state_d = LEN;
`ifdef PROM_LOADER_CHECKSUM_EN
                    sum_d   = 8'h00;
`endif
                end
            end
            LEN: begin
                if (byte_acc) begin
                    if (rx_data_i != 8'd0 && {1'b0, rx_data_i} <= MAX_LEN) begin
                        state_d = LO;
                        addr_d  = '0;
                        cnt_d   = rx_data_i;
`ifdef PROM_LOADER_CHECKSUM_EN
                        sum_d   = sum_next;
`endif
                    end else begin
                        state_d = ERROR;
                    end
                end else if (timer_expired) begin
                    state_d = ERROR;
                end
            end
            LO: begin
                if (byte_acc) begin
                    state_d = HI;
                    lo_d    = rx_data_i;
`ifdef PROM_LOADER_CHECKSUM_EN
                    sum_d   = sum_next;
`endif
                end else if (timer_expired) begin
                    state_d = ERROR;
                end
            end
            HI: begin
                if (byte_acc) begin
                    state_d = WRITE;
                    data_d  = {rx_data_i, lo_q};
`ifdef PROM_LOADER_CHECKSUM_EN
                    sum_d   = sum_next;
`endif
                end else if (timer_expired) begin
                    state_d = ERROR;
                end
            end
            // The address only advances when another word follows, so it never wraps.
            WRITE: begin
                if (cnt_q > 8'd1) begin
                    state_d = LO;
                    cnt_d   = cnt_q - 8'd1;
                    addr_d  = addr_q + AW'(1);
                end else begin
`ifdef PROM_LOADER_CHECKSUM_EN
                    state_d = CHK;
`else
                    state_d = DONE;
`endif
                end
            end
`ifdef PROM_LOADER_CHECKSUM_EN
            CHK: begin
                if (byte_acc) begin
                    state_d = (sum_next == 8'h00) ? DONE : ERROR;
                end else if (timer_expired) begin
                    state_d = ERROR;
                end
            end
`endif
            default: state_d = HUNT;
        endcase

        // Outputs are registered from the next state so they line up with it.
        we_d        = (state_d == WRITE);
        ack_d       = (state_d != WRITE);
        cpu_reset_d = (state_d != DONE);
        busy_d      = is_loading(state_d);
        done_d      = (state_d == DONE);
        error_d     = (state_d == ERROR);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= HUNT;
            addr_q      <= '0;
            cnt_q       <= '0;
            lo_q        <= '0;
            data_q      <= '0;
            we_q        <= 1'b0;
            ack_q       <= 1'b1;
            cpu_reset_q <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            cnt_q       <= cnt_d;
            lo_q        <= lo_d;
            data_q      <= data_d;
            we_q        <= we_d;
            ack_q       <= ack_d;
            cpu_reset_q <= cpu_reset_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            error_q     <= error_d;
        end
    end

`ifdef PROM_LOADER_CHECKSUM_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sum_q <= 8'h00;
        end else begin
            sum_q <= sum_d;
        end
    end
`endif

    assign rx_ack_o     = ack_q;
    assign prom_we_o    = we_q;
    assign prom_addr_o  = addr_q;
    assign prom_data_o  = data_q;
    assign cpu_reset_o  = cpu_reset_q;
    assign load_busy_o  = busy_q;
    assign load_done_o  = done_q;
    assign load_error_o = error_q;

endmodule

// File: tb/tb_prom_loader.sv
// Scoreboard bench for prom_loader: frames are built from the wire-format rules, expected
// PROM writes and load outcomes are queued, and negedge monitors pop and compare them.
module tb_prom_loader;

    localparam int ROM_WORDS     = 16;
    localparam int TIMEOUT_TICKS = 625;
    localparam int AW            = $clog2(ROM_WORDS);

`ifdef PROM_LOADER_CHECKSUM_EN
    localparam bit CHECKSUM_ON = 1'b1;
`else
    localparam bit CHECKSUM_ON = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic [7:0]    rx_data_i = 8'h00;
    logic          rx_ready_i = 1'b0;
    logic          rx_ack_o;
    logic          prom_we_o;
    logic [AW-1:0] prom_addr_o;
    logic [15:0]   prom_data_o;
    logic          cpu_reset_o;
    logic          load_busy_o;
    logic          load_done_o;
    logic          load_error_o;

    int tests = 0;
    int fails = 0;

    logic [AW+15:0] exp_writes[$];
    logic [1:0]     exp_outcome[$];
    logic [15:0]    frame_words[ROM_WORDS];
    bit             prev_busy = 1'b0;

    prom_loader #(
        .ROM_WORDS    (ROM_WORDS),
        .TIMEOUT_TICKS(TIMEOUT_TICKS)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .rx_data_i   (rx_data_i),
        .rx_ready_i  (rx_ready_i),
        .rx_ack_o    (rx_ack_o),
        .prom_we_o   (prom_we_o),
        .prom_addr_o (prom_addr_o),
        .prom_data_o (prom_data_o),
        .cpu_reset_o (cpu_reset_o),
        .load_busy_o (load_busy_o),
        .load_done_o (load_done_o),
        .load_error_o(load_error_o)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        tests++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_cpu_reset"}, cpu_reset_o, 1);
        checkOutput({tag, "_rx_ack"}, rx_ack_o, 1);
        checkOutput({tag, "_we"}, prom_we_o, 0);
        checkOutput({tag, "_addr"}, prom_addr_o, 0);
        checkOutput({tag, "_busy_done_error"}, {load_busy_o, load_done_o, load_error_o}, 3'b000);
    endtask

    // Presents one byte at a negedge and returns at the negedge after it was taken.
    task automatic sendByte(input logic [7:0] b, input bit hold);
        bit taken = 1'b0;
        rx_data_i  = b;
        rx_ready_i = 1'b1;
        for (int t = 0; t < 4 && !taken; t++) begin
            if (rx_ack_o) taken = 1'b1;
            @(negedge clk);
        end
        if (!taken) begin
            tests++;
            fails++;
            $display("[TB] FAIL byte_accept: byte %0h not taken within 4 cycles, required 1", b);
        end
        if (!hold) rx_ready_i = 1'b0;
    endtask

    // Builds a frame from frame_words, queues the expected writes and outcome, then sends
    // the first keep_bytes bytes (all when negative). A truncated frame is followed by idle
    // clocks and an exact check of the timeout boundary.
    task automatic applyStimulus(input logic [7:0] len, input logic [7:0] chk_delta,
                                 input int keep_bytes, input bit b2b);
        logic [7:0] bytes[$];
        logic [7:0] sum;
        bit         len_ok;
        int         n;
        int         extra;
        len_ok = (len >= 8'd1) && (int'(len) <= ROM_WORDS);
        bytes.push_back(8'hA5);
        bytes.push_back(len);
        if (len_ok) begin
            sum = len;
            for (int i = 0; i < int'(len); i++) begin
                bytes.push_back(frame_words[i][7:0]);
                bytes.push_back(frame_words[i][15:8]);
                sum = sum + frame_words[i][7:0] + frame_words[i][15:8];
            end
            if (CHECKSUM_ON) bytes.push_back(8'(8'h00 - sum + chk_delta));
        end
        n = (keep_bytes < 0 || keep_bytes > bytes.size()) ? bytes.size() : keep_bytes;
        if (len_ok) begin
            for (int i = 0; i < int'(len); i++) begin
                if (3 + 2 * i < n) exp_writes.push_back({AW'(i), frame_words[i]});
            end
        end
        if (!len_ok || n < bytes.size()) exp_outcome.push_back(2'b01);
        else if (CHECKSUM_ON && chk_delta != 8'h00) exp_outcome.push_back(2'b01);
        else exp_outcome.push_back(2'b10);

        for (int k = 0; k < n; k++) begin
            if (!b2b) repeat ($urandom_range(0, 2)) @(negedge clk);
            sendByte(bytes[k], b2b && (k != n - 1));
        end

        if (n < bytes.size()) begin
            extra = (n >= 4 && n % 2 == 0) ? 1 : 0;
            repeat (TIMEOUT_TICKS - 1 + extra) @(negedge clk);
            checkOutput("timeout_not_early", {load_busy_o, load_error_o}, 2'b10);
            @(negedge clk);
            checkOutput("timeout_error", {load_busy_o, load_error_o}, 2'b01);
        end
        @(negedge clk);
    endtask

    task automatic setWords(input logic [15:0] w0, input logic [15:0] w1);
        for (int i = 0; i < ROM_WORDS; i++) frame_words[i] = 16'($urandom);
        frame_words[0] = w0;
        frame_words[1] = w1;
    endtask

    // Write monitor and outcome monitor: pop the scoreboard whenever the DUT presents a result.
    always @(negedge clk) begin
        logic [AW+15:0] w;
        logic [1:0]     o;
        if (!reset_n) begin
            prev_busy = 1'b0;
        end else begin
            if (prom_we_o) begin
                tests++;
                if (exp_writes.size() == 0) begin
                    fails++;
                    $display("[TB] FAIL write_unexpected: got addr %0h data %0h, required no write",
                             prom_addr_o, prom_data_o);
                end else begin
                    w = exp_writes.pop_front();
                    if ({prom_addr_o, prom_data_o} !== w) begin
                        fails++;
                        $display("[TB] FAIL write: got addr %0h data %0h, required addr %0h data %0h",
                                 prom_addr_o, prom_data_o, w[AW+15:16], w[15:0]);
                    end
                end
            end
            if (prev_busy && !load_busy_o) begin
                tests++;
                if (exp_outcome.size() == 0) begin
                    fails++;
                    $display("[TB] FAIL outcome_unexpected: got done %0b error %0b, required none",
                             load_done_o, load_error_o);
                end else begin
                    o = exp_outcome.pop_front();
                    if ({load_done_o, load_error_o} !== o || cpu_reset_o !== !o[1]) begin
                        fails++;
                        $display("[TB] FAIL outcome: got done %0b error %0b cpu_reset %0b, required done %0b error %0b cpu_reset %0b",
                                 load_done_o, load_error_o, cpu_reset_o, o[1], o[0], !o[1]);
                    end
                end
            end
            prev_busy = load_busy_o;
        end
    end

    initial begin
        #1000000;
        fails++;
        $display("[TB] FAIL watchdog: simulation still running at %0t, required finish", $time);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [7:0] len;
        logic [7:0] delta;
        int         kind;

        // Reset and idle bytes in HUNT.
        repeat (3) @(negedge clk);
        checkResetValues("reset_hold");
        reset_n = 1'b1;
        @(negedge clk);
        sendByte(8'h00, 1'b0);
        sendByte(8'hFF, 1'b0);
        repeat (2) @(negedge clk);
        checkResetValues("hunt_idle");

        // Known-good two-word frame.
        setWords(16'h1234, 16'h5678);
        applyStimulus(8'd2, 8'h00, -1, 1'b0);
        checkOutput("good_done", {load_done_o, cpu_reset_o}, 2'b10);

        // Corrupted checksum, then a clean retry.
        applyStimulus(8'd2, 8'h01, -1, 1'b0);
        checkOutput("badchk_result", {load_done_o, load_error_o, cpu_reset_o},
                    CHECKSUM_ON ? 3'b011 : 3'b100);
        applyStimulus(8'd2, 8'h00, -1, 1'b0);
        checkOutput("retry_done", {load_done_o, cpu_reset_o}, 2'b10);

        // Out-of-range lengths.
        applyStimulus(8'h11, 8'h00, -1, 1'b0);
        checkOutput("len_11_error", {load_error_o, cpu_reset_o}, 2'b11);
        applyStimulus(8'h00, 8'h00, -1, 1'b0);
        checkOutput("len_00_error", {load_error_o, cpu_reset_o}, 2'b11);

        // Timeout after A5 02 34, then a fresh frame.
        applyStimulus(8'd2, 8'h00, 3, 1'b0);
        applyStimulus(8'd2, 8'h00, -1, 1'b0);
        checkOutput("after_timeout_done", load_done_o, 1);

        // Reload from DONE, then reset mid-frame.
        sendByte(8'hA5, 1'b0);
        checkOutput("reload_cpu_reset", {cpu_reset_o, load_busy_o, load_done_o}, 3'b110);
        sendByte(8'h02, 1'b0);
        sendByte(8'h34, 1'b0);
        reset_n = 1'b0;
        @(negedge clk);
        checkResetValues("midframe_reset");
        #2 reset_n = 1'b1;
        @(negedge clk);
        setWords(16'hBEEF, 16'hCAFE);
        applyStimulus(8'd2, 8'h00, -1, 1'b0);
        checkOutput("post_reset_done", load_done_o, 1);

        // Full-depth frame with rx_ready held high across the WRITE stalls.
        setWords(16'($urandom), 16'($urandom));
        applyStimulus(8'(ROM_WORDS), 8'h00, -1, 1'b1);
        checkOutput("b2b_done", {load_done_o, cpu_reset_o}, 2'b10);

        // Randomised frames with stray bytes between them.
        for (int f = 0; f < 20; f++) begin
            repeat ($urandom_range(0, 2)) begin
                len = 8'($urandom_range(0, 255));
                if (len == 8'hA5) len = 8'h5A;
                sendByte(len, 1'b0);
            end
            setWords(16'($urandom), 16'($urandom));
            kind  = $urandom_range(0, 9);
            len   = 8'($urandom_range(1, ROM_WORDS));
            delta = 8'h00;
            if (kind == 0) len = ($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom_range(ROM_WORDS + 1, 255));
            if (kind == 1) delta = 8'($urandom_range(1, 255));
            applyStimulus(len, delta, -1, $urandom_range(0, 1) == 1);
        end

        repeat (5) @(negedge clk);
        checkOutput("writes_drained", exp_writes.size(), 0);
        checkOutput("outcomes_drained", exp_outcome.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
